// File: rtl/ex3_digit_assembler.sv
// Serial Excess-3 digit stream to packed-BCD word assembler with sticky per-word error flag.
// Optional EX3_ERR_FLUSH_EN: an invalid digit ends the word immediately with an all-ones word.
module ex3_digit_assembler #(
  parameter  int DIGITS = 4,
  localparam int CW     = $clog2(DIGITS + 1),
  localparam int W      = 4 * DIGITS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [3:0]    in_digit,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_bcd,
  output logic          out_err,
  output logic [CW-1:0] digit_cnt
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            bad;
  logic [3:0]      nib;

  assign bad = (in_digit < 4'h3) || (in_digit > 4'hC);
  assign nib = bad ? 4'hF : in_digit - 4'h3;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      COLLECT: if (in_valid) begin
        shreg_d = {shreg_q[W-5:0], nib};
        err_d   = err_q | bad;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(DIGITS - 1)) state_d = HOLD;
`ifdef EX3_ERR_FLUSH_EN
        // Bad digit aborts the word; whatever was collected is replaced by all ones.
        if (bad) begin
          shreg_d = '1;
          state_d = HOLD;
        end
`endif
      end
      HOLD: if (out_ready) begin
        state_d = COLLECT;
        shreg_d = '0;
        err_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      shreg_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_bcd   = shreg_q;
  assign out_err   = err_q;
  assign digit_cnt = cnt_q;

endmodule

// File: tb/tb_ex3_digit_assembler.sv
// Directed + random bench for ex3_digit_assembler; expected words queued on digit acceptance,
// popped and compared on each output handshake.
module tb_ex3_digit_assembler;
  localparam int DIGITS = 4;
  localparam int CW = $clog2(DIGITS + 1);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_err;
  logic [3:0]  in_digit;
  logic [15:0] out_bcd;
  logic [CW-1:0] digit_cnt;

  ex3_digit_assembler #(.DIGITS(DIGITS)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_bcd(out_bcd), .out_err(out_err), .digit_cnt(digit_cnt)
  );

  always #5 clk = ~clk;

  int errs = 0, checks = 0;
  int lo_cnt, vld_cnt, nwords;
  logic last_in_hs;
  logic [16:0] sb[$];
  logic [15:0] m_bcd;
  logic        m_err;
  int          m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    m_bcd = '0; m_err = 1'b0; m_cnt = 0;
  endtask

  task automatic model_digit(input logic [3:0] d);
    logic b;
    b = (d < 4'h3) || (d > 4'hC);
    m_bcd = {m_bcd[11:0], b ? 4'hF : 4'(d - 4'h3)};
    m_err = m_err | b;
    m_cnt++;
`ifdef EX3_ERR_FLUSH_EN
    if (b) begin
      sb.push_back({1'b1, 16'hFFFF});
      model_clear();
      return;
    end
`endif
    if (m_cnt == DIGITS) begin
      sb.push_back({m_err, m_bcd});
      model_clear();
    end
  endtask

  // One clock cycle: drive, observe handshakes mid-cycle, advance past the edge.
  task automatic cyc(input logic v, input logic [3:0] d, input logic r);
    logic [16:0] exp;
    in_valid = v; in_digit = d; out_ready = r;
    @(negedge clk);
    last_in_hs = in_valid && in_ready;
    if (!in_ready) lo_cnt++;
    if (out_valid) vld_cnt++;
    if (out_valid && out_ready) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        exp = sb.pop_front();
        chk("word", {15'd0, out_err, out_bcd}, {15'd0, exp});
        nwords++;
      end
    end
    if (last_in_hs) model_digit(in_digit);
    @(posedge clk); #1;
  endtask

  logic        pend;
  logic [3:0]  pd;
  logic        rv;
  int          guard;

  initial begin
    model_clear();
    nwords = 0; lo_cnt = 0; vld_cnt = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_digit = 4'h0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_bcd", 32'(out_bcd), 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_digit_cnt", 32'(digit_cnt), 32'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // back-to-back word with out_ready already high
    lo_cnt = 0; vld_cnt = 0;
    cyc(1, 4'h4, 1); cyc(1, 4'h5, 1); cyc(1, 4'h6, 1); cyc(1, 4'h7, 1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_bcd", 32'(out_bcd), 32'h1234);
    chk("t1_cnt", 32'(digit_cnt), 32'd4);
    cyc(0, 4'h0, 1); cyc(0, 4'h0, 1);
    chk("t1_ready_low_cycles", 32'(lo_cnt), 32'd1);
    chk("t1_valid_cycles", 32'(vld_cnt), 32'd1);
    chk("t1_back_collect", 32'(in_ready), 32'd1);

    // stalled output, digit offered during HOLD must wait
    cyc(1, 4'h3, 0); cyc(1, 4'hC, 0); cyc(1, 4'h3, 0); cyc(1, 4'hC, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 4'h4, 0);
      chk("t2_hold_bcd", 32'(out_bcd), 32'h0909);
      chk("t2_hold_consumed", 32'(last_in_hs), 32'd0);
    end
    cyc(1, 4'h4, 1);
    chk("t2_hs_not_consumed", 32'(last_in_hs), 32'd0);
    cyc(1, 4'h4, 0);
    chk("t2_next_consumed", 32'(last_in_hs), 32'd1);
    cyc(1, 4'h4, 1); cyc(1, 4'h4, 1); cyc(1, 4'h4, 1);
    cyc(0, 4'h0, 1);

    // invalid digit handling
    cyc(1, 4'h4, 0); cyc(1, 4'h2, 0);
`ifdef EX3_ERR_FLUSH_EN
    chk("t3_flush_valid", 32'(out_valid), 32'd1);
    chk("t3_flush_bcd", 32'(out_bcd), 32'hFFFF);
    chk("t3_flush_err", 32'(out_err), 32'd1);
    chk("t3_flush_cnt", 32'(digit_cnt), 32'd2);
    cyc(0, 4'h0, 1);
    cyc(1, 4'h6, 0); cyc(1, 4'h7, 0); cyc(1, 4'h8, 0); cyc(1, 4'h9, 0);
    chk("t3_next_bcd", 32'(out_bcd), 32'h3456);
    chk("t3_next_err", 32'(out_err), 32'd0);
    cyc(0, 4'h0, 1);
`else
    cyc(1, 4'h6, 0); cyc(1, 4'h7, 0);
    chk("t3_bad_bcd", 32'(out_bcd), 32'h1F34);
    chk("t3_bad_err", 32'(out_err), 32'd1);
    cyc(0, 4'h0, 1);
    cyc(1, 4'h4, 0); cyc(1, 4'h4, 0); cyc(1, 4'h4, 0); cyc(1, 4'h4, 0);
    chk("t3_next_bcd", 32'(out_bcd), 32'h1111);
    chk("t3_err_cleared", 32'(out_err), 32'd0);
    cyc(0, 4'h0, 1);
`endif

    // asynchronous reset mid-word
    cyc(1, 4'h4, 0); cyc(1, 4'h5, 0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t4_rst_valid", 32'(out_valid), 32'd0);
    chk("t4_rst_cnt", 32'(digit_cnt), 32'd0);
    chk("t4_rst_bcd", 32'(out_bcd), 32'd0);
    chk("t4_rst_ready", 32'(in_ready), 32'd1);
    model_clear();
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1, 4'h8, 0); cyc(1, 4'h8, 0); cyc(1, 4'h8, 0); cyc(1, 4'h8, 0);
    chk("t4_after_bcd", 32'(out_bcd), 32'h5555);
    cyc(0, 4'h0, 1);

    // random gaps, 1000 words
    nwords = 0; pend = 1'b0; pd = 4'h0; guard = 0;
    while (nwords < 1000 && guard < 60000) begin
      if (!pend && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        if ($urandom_range(0, 15) == 0)
          pd = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 2)) : 4'($urandom_range(13, 15));
        else
          pd = 4'($urandom_range(3, 12));
      end
      rv = ($urandom_range(0, 2) != 0);
      cyc(pend, pend ? pd : 4'h0, rv);
      if (last_in_hs) pend = 1'b0;
      guard++;
    end
    chk("rand_words_done", 32'(nwords >= 1000), 32'd1);
    // flush any partial word still pending
    for (int i = 0; i < 20 && (m_cnt != 0 || sb.size() != 0); i++)
      cyc(m_cnt != 0, 4'h5, 1);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
